multi_channel_sampler: RTL and testbench
========================================

Name: multi_channel_sampler

Overview:
- Parametrised successor to the single-channel IAGC sampler.
- Captures NUM_CHANNELS packed input channels into sample memory.
- Run-time power-of-two decimation, with drop or average selectable.
- Modes: gated (start on i_gate rising edge, pause while low) or continuous (runs from arm until memory full).
- Sits between the ADC front-end and the dual-port sample RAM. The IAGC controller arms it via i_iagc_status and reads memory after o_end.

Parameters:
- DATA_SIZE, 16, width of one channel sample (unsigned).
- ADDR_SIZE, 12, memory address width.
- MEMORY_SIZE, 1024, words available; must be a multiple of NUM_CHANNELS.
- NUM_CHANNELS, 2, channels captured per frame (1..8).
- DECIM_LOG2_MAX, 4, maximum decimation exponent.
- IAGC_STATUS_SIZE, 4, width of the controller status bus.
- END_HOLD, 4, cycles o_end stays high.

Ports:
- i_clock, in, 1: single system clock; all logic on rising edge.
- i_reset, in, 1: synchronous, active-high reset.
- i_data, in, NUM_CHANNELS*DATA_SIZE: channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
- i_gate, in, 1: acquisition gate (gated mode only).
- i_iagc_status, in, IAGC_STATUS_SIZE: controller state; 4'b0000 = soft reset, 4'b0011 = SAMPLE (arm).
- i_mode, in, 1: 0 = gated, 1 = continuous; latched on arm.
- i_average, in, 1: 0 = drop (keep last sample of window), 1 = mean of window; latched on arm.
- i_decim_log2, in, clog2(DECIM_LOG2_MAX+1): decimation D = 2^value, clamped to DECIM_LOG2_MAX; latched on arm.
- o_wr_en, out, 1: memory write strobe.
- o_addr, out, ADDR_SIZE: write address.
- o_data, out, DATA_SIZE: write data.
- o_end, out, 1: capture complete, high for END_HOLD cycles.
- o_overrun, out, 1: sticky; a decimation tick was dropped.
- o_busy, out, 1: state is not IDLE.

Behaviour:
Reset and idle
- On i_reset, or when i_iagc_status == 4'b0000, the block reverts to IDLE. In this state every output is 0, o_overrun is cleared, and all counters are zeroed.
- i_reset takes effect even mid-write; any partial frame is discarded.

States
- IDLE: entered from reset or at END completion. Moves to ARMED when i_iagc_status == SAMPLE; mode, average and decimation settings are latched on that edge.
- ARMED:
  - Gated mode: moves to ACQUIRE when i_gate=1 and the registered last_gate=0.
  - Continuous mode: moves to ACQUIRE on the next cycle unconditionally.
  - frame_idx is preserved across pauses.
- ACQUIRE:
  - Each cycle, win_cnt increments. The accumulator adds every channel's i_data; accumulator width is DATA_SIZE+DECIM_LOG2_MAX per channel.
  - When win_cnt == D-1 a tick occurs: hold[c] <= i_average ? (acc[c]+i_data[c]) >> log2 : i_data[c]. The accumulator and win_cnt then clear and flush starts.
  - Gated mode with i_gate=0: returns to ARMED and clears win_cnt and the accumulator. Any partial window is discarded, but an in-progress flush completes.
- END: o_end=1 for END_HOLD cycles, then IDLE.

Flush (write serialiser)
- Starts the cycle after a tick and writes channels 0..NUM_CHANNELS-1 on consecutive cycles: o_wr_en=1, o_addr = frame_idx*NUM_CHANNELS + ch, o_data = hold[ch].
- After the last channel, frame_idx increments.
- If frame_idx reaches MEMORY_SIZE/NUM_CHANNELS, the next state is END and further ticks are ignored.
- A tick arriving while a flush is active is dropped and sets o_overrun. This cannot happen when D >= NUM_CHANNELS.
- D=1 with NUM_CHANNELS=1 gives one write per cycle with no overrun.

Other rules
- Simultaneous gate fall and tick: the tick is taken, then the block pauses.
- Arm while not IDLE: ignored.
- Addresses never wrap; capture stops at the last word.

Decomposition:
- Package sampler_pkg: IAGC status encodings (RESET=0, INIT=1, IDLE=2, SAMPLE=3, CMD_PARSE=4, CMD_READ=5, CMD_ERROR=6, DUMP_MEM=7), the state encodings IDLE/ARMED/ACQUIRE/END, and the mode constants.
- One sub-module: sample_decimator. It covers one channel's accumulate/drop and hold register, and is instantiated NUM_CHANNELS times via generate. The top level holds the FSM, gate edge detector and write serialiser.

Test Plan:
- Continuous, drop, NUM_CHANNELS=2, log2=2, MEMORY_SIZE=8; ch0=n, ch1=100+n ramp from ACQUIRE cycle 0 -> writes (0,3),(1,103),(2,7),(3,107)...(7,115); o_end high 4 cycles; o_overrun=0.
- Same setup with average=1 -> first frame writes (0,1),(1,101) (mean of 0..3 = 6>>2); second frame (2,5),(3,105).
- Gated, log2=2: gate high 6 cycles, low 3, high 4 -> first run writes frame 0; the 2-cycle partial window is discarded. Second run writes frame 1 at addresses 2 and 3; no address gap.
- NUM_CHANNELS=4, log2=1 (D=2): second tick lands mid-flush -> o_overrun=1 and stays 1; only every other window is written.
- i_reset asserted during the flush of channel 1 -> next cycle o_wr_en=0, o_busy=0, o_addr=0. Re-arm restarts at address 0.
- i_iagc_status forced to 4'b0000 during END -> o_end drops next cycle and the block returns to IDLE.

Source files
------------

// File: rtl/sampler_pkg.sv
// Shared encodings for the multi-channel sampler: IAGC controller
// status values, sampler FSM states and capture mode constants.
package sampler_pkg;

   localparam logic [3:0] IAGC_RESET     = 4'd0;
   localparam logic [3:0] IAGC_INIT      = 4'd1;
   localparam logic [3:0] IAGC_IDLE      = 4'd2;
   localparam logic [3:0] IAGC_SAMPLE    = 4'd3;
   localparam logic [3:0] IAGC_CMD_PARSE = 4'd4;
   localparam logic [3:0] IAGC_CMD_READ  = 4'd5;
   localparam logic [3:0] IAGC_CMD_ERROR = 4'd6;
   localparam logic [3:0] IAGC_DUMP_MEM  = 4'd7;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_ACQUIRE = 2'd2;
   localparam logic [1:0] ST_END     = 2'd3;

   localparam logic MODE_GATED = 1'b0;
   localparam logic MODE_CONT  = 1'b1;
   localparam logic AVG_DROP   = 1'b0;
   localparam logic AVG_MEAN   = 1'b1;

endpackage

// File: rtl/sample_decimator.sv
// One channel of the sampler: window accumulator and the hold register
// that the write serialiser reads from.
module sample_decimator
   import sampler_pkg::*;
#(
   parameter int DATA_SIZE      = 16,
   parameter int DECIM_LOG2_MAX = 4,
   parameter int LOG2_W         = 3
) (
   input  logic                 i_clock,
   input  logic                 i_clear,
   input  logic                 i_acc_en,
   input  logic                 i_acc_clr,
   input  logic                 i_load,
   input  logic                 i_average,
   input  logic [LOG2_W-1:0]    i_log2,
   input  logic [DATA_SIZE-1:0] i_data,
   output logic [DATA_SIZE-1:0] o_hold
);

   localparam int ACC_W = DATA_SIZE + DECIM_LOG2_MAX;

   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     sum;
   logic [DATA_SIZE-1:0] mean;

   assign sum  = acc + ACC_W'(i_data);
   assign mean = DATA_SIZE'(sum >> i_log2);

   always_ff @(posedge i_clock) begin
      if (i_clear) begin
         acc    <= '0;
         o_hold <= '0;
      end else begin
         if (i_acc_clr)
            acc <= '0;
         else if (i_acc_en)
            acc <= sum;
         // the tick sample itself is part of the window
         if (i_load)
            o_hold <= (i_average == AVG_MEAN) ? mean : i_data;
      end
   end

endmodule

// File: rtl/multi_channel_sampler.sv
// Multi-channel decimating sampler: capture FSM, gate edge detector and
// the serialiser that writes one frame of channels into sample RAM.
module multi_channel_sampler
   import sampler_pkg::*;
#(
   parameter int DATA_SIZE        = 16,
   parameter int ADDR_SIZE        = 12,
   parameter int MEMORY_SIZE      = 1024,
   parameter int NUM_CHANNELS     = 2,
   parameter int DECIM_LOG2_MAX   = 4,
   parameter int IAGC_STATUS_SIZE = 4,
   parameter int END_HOLD         = 4
) (
   input  logic                                 i_clock,
   input  logic                                 i_reset,
   input  logic [NUM_CHANNELS*DATA_SIZE-1:0]    i_data,
   input  logic                                 i_gate,
   input  logic [IAGC_STATUS_SIZE-1:0]          i_iagc_status,
   input  logic                                 i_mode,
   input  logic                                 i_average,
   input  logic [$clog2(DECIM_LOG2_MAX+1)-1:0]  i_decim_log2,
   output logic                                 o_wr_en,
   output logic [ADDR_SIZE-1:0]                 o_addr,
   output logic [DATA_SIZE-1:0]                 o_data,
   output logic                                 o_end,
   output logic                                 o_overrun,
   output logic                                 o_busy
);

   localparam int FRAMES = MEMORY_SIZE / NUM_CHANNELS;
   localparam int LOG2_W = $clog2(DECIM_LOG2_MAX + 1);
   localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int WIN_W  = (DECIM_LOG2_MAX > 0) ? DECIM_LOG2_MAX : 1;
   localparam int END_W  = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;

   logic [1:0]           state;
   logic                 mode;
   logic                 average;
   logic [LOG2_W-1:0]    dlog;
   logic                 last_gate;
   logic [WIN_W-1:0]     win_cnt;
   logic [ADDR_SIZE-1:0] frame_idx;
   logic [CH_W-1:0]      ch;
   logic                 flushing;
   logic [END_W-1:0]     end_cnt;
   logic                 overrun;

   logic                 clear;
   logic                 arm;
   logic                 in_acq;
   logic [WIN_W-1:0]     d_m1;
   logic                 tick;
   logic                 pause;
   logic                 last_wr;
   logic                 full_wr;
   logic                 take;
   logic                 drop;
   logic [DATA_SIZE-1:0] hold [NUM_CHANNELS];

   assign clear  = i_reset ||
                   (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_RESET));
   assign arm    = i_iagc_status == IAGC_STATUS_SIZE'(IAGC_SAMPLE);
   assign in_acq = state == ST_ACQUIRE;
   assign d_m1   = WIN_W'((1 << dlog) - 1);
   assign tick   = in_acq && (win_cnt == d_m1);
   assign pause  = in_acq && (mode == MODE_GATED) && !i_gate;

   // a tick is accepted while the last channel of a frame is going out
   assign last_wr = flushing && (ch == CH_W'(NUM_CHANNELS - 1));
   assign full_wr = last_wr && (frame_idx == ADDR_SIZE'(FRAMES - 1));
   assign take    = tick && (!flushing || last_wr) && !full_wr;
   assign drop    = tick && flushing && !last_wr;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      sample_decimator #(
         .DATA_SIZE      (DATA_SIZE),
         .DECIM_LOG2_MAX (DECIM_LOG2_MAX),
         .LOG2_W         (LOG2_W)
      ) u_dec (
         .i_clock   (i_clock),
         .i_clear   (clear),
         .i_acc_en  (in_acq),
         .i_acc_clr (!in_acq || tick || pause),
         .i_load    (take),
         .i_average (average),
         .i_log2    (dlog),
         .i_data    (i_data[c*DATA_SIZE +: DATA_SIZE]),
         .o_hold    (hold[c])
      );
   end

   always_ff @(posedge i_clock) begin
      if (clear) begin
         state     <= ST_IDLE;
         mode      <= MODE_GATED;
         average   <= AVG_DROP;
         dlog      <= '0;
         last_gate <= 1'b0;
         win_cnt   <= '0;
         frame_idx <= '0;
         ch        <= '0;
         flushing  <= 1'b0;
         end_cnt   <= '0;
         overrun   <= 1'b0;
      end else begin
         last_gate <= i_gate;
         unique case (state)
            ST_IDLE: begin
               win_cnt   <= '0;
               frame_idx <= '0;
               ch        <= '0;
               flushing  <= 1'b0;
               end_cnt   <= '0;
               overrun   <= 1'b0;
               if (arm) begin
                  state   <= ST_ARMED;
                  mode    <= i_mode;
                  average <= i_average;
                  dlog    <= (i_decim_log2 > LOG2_W'(DECIM_LOG2_MAX)) ?
                             LOG2_W'(DECIM_LOG2_MAX) : i_decim_log2;
               end
            end
            ST_ARMED: begin
               if (mode == MODE_CONT || (i_gate && !last_gate))
                  state <= ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               win_cnt <= (tick || pause) ? '0 : win_cnt + 1'b1;
               if (pause)
                  state <= ST_ARMED;
            end
            default: begin
               if (end_cnt == END_W'(END_HOLD - 1)) begin
                  state   <= ST_IDLE;
                  end_cnt <= '0;
               end else begin
                  end_cnt <= end_cnt + 1'b1;
               end
            end
         endcase
         // serialiser runs independently of pauses; a full memory wins
         if (flushing) begin
            if (last_wr) begin
               ch        <= '0;
               frame_idx <= frame_idx + 1'b1;
               flushing  <= take;
               if (full_wr)
                  state <= ST_END;
            end else begin
               ch <= ch + 1'b1;
            end
         end else if (take) begin
            flushing <= 1'b1;
            ch       <= '0;
         end
         if (drop)
            overrun <= 1'b1;
      end
   end

   assign o_wr_en   = flushing;
   assign o_addr    = flushing ?
                      ADDR_SIZE'(frame_idx * NUM_CHANNELS) + ADDR_SIZE'(ch) :
                      '0;
   assign o_data    = flushing ? hold[ch] : '0;
   assign o_end     = state == ST_END;
   assign o_overrun = overrun;
   assign o_busy    = state != ST_IDLE;

endmodule

// File: tb/tb_multi_channel_sampler.sv
// Randomised scoreboard bench for multi_channel_sampler (2 channels,
// 8-word memory) against a window-level reference model.
module tb_multi_channel_sampler;

   localparam int DS  = 16;
   localparam int AS  = 12;
   localparam int MEM = 8;
   localparam int NC  = 2;
   localparam int DLM = 4;
   localparam int EH  = 4;
   localparam int FRAMES = MEM / NC;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   data;
   logic          gate;
   logic [3:0]    status;
   logic          mode;
   logic          avg;
   logic [2:0]    dlog;
   logic          wr_en;
   logic [AS-1:0] addr;
   logic [DS-1:0] wr_data;
   logic          done;
   logic          overrun;
   logic          busy;

   multi_channel_sampler #(
      .DATA_SIZE        (DS),
      .ADDR_SIZE        (AS),
      .MEMORY_SIZE      (MEM),
      .NUM_CHANNELS     (NC),
      .DECIM_LOG2_MAX   (DLM),
      .IAGC_STATUS_SIZE (4),
      .END_HOLD         (EH)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_data        (data),
      .i_gate        (gate),
      .i_iagc_status (status),
      .i_mode        (mode),
      .i_average     (avg),
      .i_decim_log2  (dlog),
      .o_wr_en       (wr_en),
      .o_addr        (addr),
      .o_data        (wr_data),
      .o_end         (done),
      .o_overrun     (overrun),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int val;
   } wr_t;

   wr_t         sbq[$];
   int          checks = 0;
   int          passes = 0;
   int          end_cycles = 0;
   logic [15:0] memimg [MEM];
   bit          wr_seen [MEM];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act == exp)
         passes++;
      else
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // monitor: every presented write is popped and compared
   always @(negedge clk) begin
      wr_t e;
      if (done)
         end_cycles++;
      if (wr_en) begin
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: got addr %0d data %0d expected none",
                     addr, wr_data);
         end else begin
            e = sbq.pop_front();
            chk("wr_addr", addr, e.addr);
            chk("wr_data", wr_data, e.val);
         end
         if (addr < MEM) begin
            memimg[addr] = wr_data;
            wr_seen[addr] = 1'b1;
         end
      end
   end

   // reference model: windows of samples, frames and writer availability
   int          m_phase = 0;
   bit          m_prev_gate = 0;
   bit          m_mode;
   bit          m_avg;
   int          m_d;
   int          m_frames = 0;
   int          m_free = 0;
   int          m_cyc = 0;
   int          m_done_cyc = 0;
   bit          m_ovr = 0;
   logic [31:0] winq[$];

   task automatic model_step();
      logic [31:0] w;
      int          acc;
      wr_t         e;
      if (rst || status == 4'd0) begin
         m_phase = 0;
         winq.delete();
         m_frames = 0;
         m_free = 0;
         m_ovr = 0;
         m_prev_gate = 0;
         m_cyc++;
         return;
      end
      if ((m_phase == 1 || m_phase == 2) && m_frames == FRAMES &&
          m_cyc >= m_free) begin
         m_phase = 3;
         m_done_cyc = m_cyc;
      end else begin
         case (m_phase)
            0: if (status == 4'd3) begin
               m_phase = 1;
               m_mode = mode;
               m_avg = avg;
               m_d = 1 << ((dlog > 3'd4) ? 4 : int'(dlog));
               winq.delete();
               m_frames = 0;
               m_free = 0;
               m_ovr = 0;
            end
            1: if (m_mode || (gate && !m_prev_gate))
               m_phase = 2;
            2: begin
               winq.push_back(data);
               if (winq.size() == m_d) begin
                  if (m_cyc < m_free) begin
                     m_ovr = 1;
                  end else if (m_frames < FRAMES) begin
                     for (int c = 0; c < NC; c++) begin
                        acc = 0;
                        for (int i = 0; i < winq.size(); i++) begin
                           w = winq[i];
                           acc += int'(w[c*DS +: DS]);
                        end
                        w = winq[winq.size() - 1];
                        e.addr = m_frames * NC + c;
                        e.val = m_avg ? acc / m_d : int'(w[c*DS +: DS]);
                        sbq.push_back(e);
                     end
                     m_frames++;
                     m_free = m_cyc + NC;
                  end
                  winq.delete();
               end
               if (!m_mode && !gate) begin
                  m_phase = 1;
                  winq.delete();
               end
            end
            default: if (m_cyc >= m_done_cyc + EH)
               m_phase = 0;
         endcase
      end
      m_prev_gate = gate;
      m_cyc++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_img();
      for (int i = 0; i < MEM; i++) begin
         memimg[i] = '0;
         wr_seen[i] = 1'b0;
      end
   endtask

   task automatic arm(input bit md, input bit av, input int lg);
      mode = md;
      avg = av;
      dlog = 3'(lg);
      status = 4'd3;
      step();
      status = 4'd2;
   endtask

   task automatic run_cont(input bit av, input int lg, input bit ramp);
      bit seen;
      seen = 0;
      end_cycles = 0;
      clear_img();
      arm(1'b1, av, lg);
      for (int k = 0; k < 400; k++) begin
         data = ramp ? {16'(99 + k), 16'(k - 1)} : $urandom;
         step();
         if (done && !seen) begin
            seen = 1;
            chk("overrun_at_end", overrun, m_ovr);
         end
         if (!busy)
            break;
      end
      chk("end_reached", seen, 1);
      chk("end_hold_cycles", end_cycles, EH);
      chk("sb_drained", sbq.size(), 0);
      sbq.delete();
   endtask

   task automatic gate_cycles(input bit g, input int n);
      gate = g;
      for (int i = 0; i < n; i++) begin
         data = $urandom;
         step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit found;
      rst = 1'b1;
      data = '0;
      gate = 1'b0;
      status = 4'd2;
      mode = 1'b0;
      avg = 1'b0;
      dlog = '0;
      @(posedge clk);
      #1;
      step();
      step();
      rst = 1'b0;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_end", done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      step();

      // ramp, drop, D=4
      run_cont(1'b0, 2, 1'b1);
      chk("drop_mem0", memimg[0], 3);
      chk("drop_mem1", memimg[1], 103);
      chk("drop_mem6", memimg[6], 15);
      chk("drop_mem7", memimg[7], 115);
      chk("drop_no_overrun_after", overrun, 0);

      // ramp, average, D=4
      run_cont(1'b1, 2, 1'b1);
      chk("avg_mem0", memimg[0], 1);
      chk("avg_mem1", memimg[1], 101);
      chk("avg_mem2", memimg[2], 5);
      chk("avg_mem3", memimg[3], 105);

      // D=1 with two channels drops every other tick
      run_cont(1'b0, 0, 1'b0);
      // out-of-range exponent clamps to D=16
      run_cont(1'b1, 7, 1'b0);
      for (int r = 0; r < 4; r++)
         run_cont(1'($urandom), int'($urandom_range(0, 5)), 1'b0);

      // gated: 6 high, 3 low, 4 high
      clear_img();
      gate = 1'b0;
      arm(1'b0, 1'b0, 2);
      gate_cycles(1'b0, 2);
      gate_cycles(1'b1, 6);
      gate_cycles(1'b0, 3);
      gate_cycles(1'b1, 4);
      gate_cycles(1'b0, 4);
      chk("gated_sb_drained", sbq.size(), 0);
      chk("gated_addr2_written", wr_seen[2], 1);
      chk("gated_addr3_written", wr_seen[3], 1);
      chk("gated_addr4_unwritten", wr_seen[4], 0);
      chk("gated_still_busy", busy, 1);
      status = 4'd0;
      step();
      chk("soft_reset_busy", busy, 0);
      status = 4'd2;
      step();

      // random gate pattern
      for (int r = 0; r < 3; r++) begin
         arm(1'b0, 1'($urandom), int'($urandom_range(0, 3)));
         for (int k = 0; k < 80; k++)
            gate_cycles(1'($urandom_range(0, 3) != 0), 1);
         gate_cycles(1'b0, 4);
         status = 4'd0;
         step();
         status = 4'd2;
         chk("rgate_sb_drained", sbq.size(), 0);
         sbq.delete();
      end

      // reset while channel 1 of a frame is being written
      found = 0;
      arm(1'b1, 1'b0, 2);
      for (int k = 0; k < 50; k++) begin
         data = $urandom;
         step();
         if (wr_en && addr == 1) begin
            found = 1;
            break;
         end
      end
      chk("rst_flush_target_found", found, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_flush_wr_en", wr_en, 0);
      chk("rst_flush_busy", busy, 0);
      chk("rst_flush_addr", addr, 0);
      chk("rst_flush_sb_empty", sbq.size(), 0);
      sbq.delete();
      run_cont(1'b0, 2, 1'b1);
      chk("rearm_mem0", memimg[0], 3);

      // soft reset during END
      found = 0;
      arm(1'b1, 1'b1, 1);
      for (int k = 0; k < 200; k++) begin
         data = $urandom;
         step();
         if (done) begin
            found = 1;
            break;
         end
      end
      chk("end_found", found, 1);
      status = 4'd0;
      step();
      status = 4'd2;
      chk("end_abort_end", done, 0);
      chk("end_abort_busy", busy, 0);
      chk("end_abort_sb", sbq.size(), 0);
      sbq.delete();
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
